// File: rtl/fp_rnd_pipe_pkg.sv
// Shared types and constants for the FP rounding back end (stage record, IEEE patterns, rm codes).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_rnd_pipe_pkg;

  // Unrounded record handed over by the int-to-float / float-to-float front end.
  typedef struct packed {
    logic        sig;
    logic [13:0] expo;
    logic [53:0] mant;
    logic [1:0]  rema;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [2:0]  grs;
    logic        snan;
    logic        qnan;
    logic        dbz;
    logic        infs;
    logic        zero;
    logic        diff;
  } fp_rnd_in_type;

  // Stage-1 register: mantissa already incremented, round/tiny decisions made.
  typedef struct packed {
    logic        sig;
    logic [13:0] expo;
    logic [53:0] mant;
    logic        fmt_d;
    logic [2:0]  rm;
    logic        inexact;
    logic        tiny;
    logic        snan;
    logic        qnan;
    logic        dbz;
    logic        infs;
    logic        zero;
  } fp_rnd_pipe_reg_type;

  localparam logic [1:0]  FMT_D  = 2'd1;

  localparam logic [2:0]  RNE    = 3'd0;
  localparam logic [2:0]  RTZ    = 3'd1;
  localparam logic [2:0]  RDN    = 3'd2;
  localparam logic [2:0]  RUP    = 3'd3;
  localparam logic [2:0]  RMM    = 3'd4;

  localparam logic [13:0] EMAX_S = 14'd255;
  localparam logic [13:0] EMAX_D = 14'd2047;

  localparam logic [31:0] CNAN_S = 32'h7FC0_0000;
  localparam logic [63:0] CNAN_D = 64'h7FF8_0000_0000_0000;
  localparam logic [31:0] INF_S  = 32'h7F80_0000;
  localparam logic [63:0] INF_D  = 64'h7FF0_0000_0000_0000;
  localparam logic [31:0] MAXF_S = 32'h7F7F_FFFF;
  localparam logic [63:0] MAXF_D = 64'h7FEF_FFFF_FFFF_FFFF;
  localparam logic [31:0] BOX_S  = 32'hFFFF_FFFF;

  // Flag vector layout {NV,DZ,OF,UF,NX}
  localparam logic [4:0]  FLG_NV = 5'b10000;
  localparam logic [4:0]  FLG_DZ = 5'b01000;
  localparam logic [4:0]  FLG_OF = 5'b00100;
  localparam logic [4:0]  FLG_UF = 5'b00010;
  localparam logic [4:0]  FLG_NX = 5'b00001;

  // Round-up decision; unknown rm codes behave as round-toward-zero.
  function automatic logic round_up(input logic [2:0] rm, input logic sig,
                                    input logic lsb, input logic [2:0] grs);
    logic odd;
    logic inexact;
    odd     = lsb | grs[1] | grs[0];
    inexact = |grs;
    case (rm)
      RNE:     round_up = grs[2] & odd;
      RTZ:     round_up = 1'b0;
      RDN:     round_up = sig & inexact;
      RUP:     round_up = ~sig & inexact;
      RMM:     round_up = grs[2];
      default: round_up = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fp_rnd_pack.sv
// Stage-2 packer: carry/subnormal exponent adjust, overflow select, special-case override.
// Latency: combinational.
// Backpressure: none (pure function of the stage-1 record).
// Ports: rnd = stage-1 record in; result = 64-bit IEEE pattern (single NaN-boxed); flags = {NV,DZ,OF,UF,NX}.
module fp_rnd_pack
  import fp_rnd_pipe_pkg::*;
#(
  parameter bit RISCV = 1'b1
) (
  input  fp_rnd_pipe_reg_type rnd,
  output logic [63:0]         result,
  output logic [4:0]          flags
);

  logic [52:0] mant_a;
  logic [13:0] expo_a;
  logic [13:0] emax;
  logic        to_inf;
  logic        nan_sig;
  logic [63:0] inf_v;
  logic [63:0] max_v;
  logic [63:0] nan_v;
  logic [63:0] zero_v;
  logic [63:0] norm_v;

  always_comb begin
    mant_a = rnd.mant[52:0];
    expo_a = rnd.expo;
    // Rounding carried out of the hidden bit: renormalise.
    if (rnd.fmt_d ? rnd.mant[53] : rnd.mant[24]) begin
      mant_a = rnd.mant[53:1];
      expo_a = rnd.expo + 14'd1;
    end
    // A subnormal that rounded up into the hidden bit becomes the smallest normal.
    if ((rnd.expo == 14'd0) && (rnd.fmt_d ? mant_a[52] : mant_a[23])) begin
      expo_a = 14'd1;
    end
    emax = rnd.fmt_d ? EMAX_D : EMAX_S;

    // Overflow goes to infinity only when the rounding direction points away from zero.
    case (rnd.rm)
      RNE, RMM: to_inf = 1'b1;
      RUP:      to_inf = ~rnd.sig;
      RDN:      to_inf = rnd.sig;
      default:  to_inf = 1'b0;
    endcase

    nan_sig = RISCV ? 1'b0 : rnd.sig;

    if (rnd.fmt_d) begin
      inf_v  = {rnd.sig, INF_D[62:0]};
      max_v  = {rnd.sig, MAXF_D[62:0]};
      nan_v  = {nan_sig, CNAN_D[62:0]};
      zero_v = {rnd.sig, 63'd0};
      norm_v = {rnd.sig, expo_a[10:0], mant_a[51:0]};
    end else begin
      inf_v  = {BOX_S, rnd.sig, INF_S[30:0]};
      max_v  = {BOX_S, rnd.sig, MAXF_S[30:0]};
      nan_v  = {BOX_S, nan_sig, CNAN_S[30:0]};
      zero_v = {BOX_S, rnd.sig, 31'd0};
      norm_v = {BOX_S, rnd.sig, expo_a[7:0], mant_a[22:0]};
    end

    if (rnd.snan) begin
      result = nan_v;
      flags  = FLG_NV;
    end else if (rnd.qnan) begin
      result = nan_v;
      flags  = 5'd0;
    end else if (rnd.dbz) begin
      result = inf_v;
      flags  = FLG_DZ;
    end else if (rnd.infs) begin
      result = inf_v;
      flags  = 5'd0;
    end else if (rnd.zero) begin
      result = zero_v;
      flags  = 5'd0;
    end else if (expo_a >= emax) begin
      result = to_inf ? inf_v : max_v;
      flags  = FLG_OF | FLG_NX;
    end else begin
      result = norm_v;
      flags  = (rnd.tiny ? FLG_UF : 5'd0) | (rnd.inexact ? FLG_NX : 5'd0);
    end
  end

endmodule

// File: rtl/fp_rnd_pipe.sv
// Two-stage FP rounding pipe: stage 1 rounds the mantissa, stage 2 packs the IEEE result and flags.
// Latency: 2 cycles from accept to out_valid when not stalled; throughput 1 per cycle.
// Backpressure: valid/ready; both stages hold while out_ready is low, in_ready drops once both are full.
// Ports: clock, reset (sync, active-low), flush; in_valid/in_ready/in_rnd; out_valid/out_ready/out_result/out_flags.
module fp_rnd_pipe
  import fp_rnd_pipe_pkg::*;
#(
  parameter bit RISCV = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  fp_rnd_in_type in_rnd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_result,
  output logic [4:0]    out_flags
);

  fp_rnd_pipe_reg_type s1_new;
  fp_rnd_pipe_reg_type s1_d;
  fp_rnd_pipe_reg_type s1_q;
  logic                s1_valid_d;
  logic                s1_valid_q;
  logic                s2_valid_d;
  logic                s2_valid_q;
  logic [63:0]         result_d;
  logic [63:0]         result_q;
  logic [4:0]          flags_d;
  logic [4:0]          flags_q;
  logic [63:0]         pack_result;
  logic [4:0]          pack_flags;
  logic                s1_advance;
  logic                inexact;
  logic                rnded;
  logic                unused_fields;

  // Front-end fields this back end has no use for.
  assign unused_fields = ^{in_rnd.rema, in_rnd.diff};

  // Stage 1: rounding increment and tininess (detected before rounding).
  always_comb begin
    inexact        = |in_rnd.grs;
    rnded          = round_up(in_rnd.rm, in_rnd.sig, in_rnd.mant[0], in_rnd.grs);
    s1_new         = '0;
    s1_new.sig     = in_rnd.sig;
    s1_new.expo    = in_rnd.expo;
    s1_new.mant    = in_rnd.mant + {53'd0, rnded};
    s1_new.fmt_d   = (in_rnd.fmt == FMT_D);
    s1_new.rm      = in_rnd.rm;
    s1_new.inexact = inexact;
    s1_new.tiny    = (in_rnd.expo == 14'd0) & inexact;
    s1_new.snan    = in_rnd.snan;
    s1_new.qnan    = in_rnd.qnan;
    s1_new.dbz     = in_rnd.dbz;
    s1_new.infs    = in_rnd.infs;
    s1_new.zero    = in_rnd.zero;
  end

  fp_rnd_pack #(
    .RISCV (RISCV)
  ) u_pack (
    .rnd    (s1_q),
    .result (pack_result),
    .flags  (pack_flags)
  );

  assign s1_advance = ~s2_valid_q | out_ready;
  assign in_ready   = ~s1_valid_q | s1_advance;

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    flags_d    = flags_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d = s1_new;
      end
    end

    if (s1_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = pack_result;
        flags_d  = pack_flags;
      end
    end

    // Flush wins over any accept or advance in the same cycle.
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      result_d   = 64'd0;
      flags_d    = 5'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= 64'd0;
      flags_q    <= 5'd0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = result_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_fp_rnd_pipe.sv
// Testbench for fp_rnd_pipe: arithmetic reference model plus scoreboard, directed and random traffic.
// Latency: checks the 2-cycle accept-to-output path and stall/flush/reset behaviour.
// Backpressure: drives randomised out_ready to exercise stalls.
module tb_fp_rnd_pipe;
  import fp_rnd_pipe_pkg::*;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  fp_rnd_in_type in_rnd = '0;
  logic          in_ready, out_valid, in_ready0, out_valid0;
  logic [63:0]   out_result, out_result0;
  logic [4:0]    out_flags, out_flags0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int cyc      = 0;

  logic [68:0] q1[$];
  logic [68:0] q0[$];
  int          qc[$];

  always #5 clock = ~clock;

  fp_rnd_pipe #(.RISCV(1'b1)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rnd(in_rnd), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags));

  fp_rnd_pipe #(.RISCV(1'b0)) dut0 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_rnd(in_rnd), .out_valid(out_valid0), .out_ready(out_ready),
    .out_result(out_result0), .out_flags(out_flags0));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] enc(input bit s, input int e, input logic [63:0] f, input bit dbl);
    if (dbl) return (64'(s) << 63) | (64'(e) << 52) | f;
    return 64'hFFFF_FFFF_0000_0000 | (64'(s) << 31) | (64'(e) << 23) | f;
  endfunction

  // Reference: treat mantissa as an integer, add the rounding increment, renormalise by magnitude.
  function automatic logic [68:0] model(input fp_rnd_in_type r, input bit riscv);
    bit dbl, nx, up, g, below, inf_dir, tiny;
    int p, emax, e;
    longint unsigned m, fmask;
    logic [63:0] res;
    logic [4:0]  fl;
    dbl   = (r.fmt == 2'd1);
    p     = dbl ? 53 : 24;
    emax  = dbl ? 2047 : 255;
    nx    = (r.grs != 3'd0);
    g     = r.grs[2];
    below = (r.grs[1:0] != 2'd0);
    case (r.rm)
      3'd0:    up = g && (below || r.mant[0]);
      3'd2:    up = r.sig && nx;
      3'd3:    up = !r.sig && nx;
      3'd4:    up = g;
      default: up = 1'b0;
    endcase
    m = r.mant;
    m = m + longint'(up);
    e = int'(r.expo);
    if (m >= (64'd1 << p)) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e == 0 && m >= (64'd1 << (p - 1))) e = 1;
    tiny    = (r.expo == 14'd0) && nx;
    fmask   = (64'd1 << (p - 1)) - 1;
    inf_dir = (r.rm == 3'd0) || (r.rm == 3'd4) || (r.rm == 3'd3 && !r.sig) || (r.rm == 3'd2 && r.sig);
    if (r.snan) begin
      res = enc(riscv ? 1'b0 : r.sig, emax, 64'd1 << (p - 2), dbl); fl = 5'b10000;
    end else if (r.qnan) begin
      res = enc(riscv ? 1'b0 : r.sig, emax, 64'd1 << (p - 2), dbl); fl = 5'b00000;
    end else if (r.dbz) begin
      res = enc(r.sig, emax, 64'd0, dbl); fl = 5'b01000;
    end else if (r.infs) begin
      res = enc(r.sig, emax, 64'd0, dbl); fl = 5'b00000;
    end else if (r.zero) begin
      res = enc(r.sig, 0, 64'd0, dbl); fl = 5'b00000;
    end else if (e >= emax) begin
      res = inf_dir ? enc(r.sig, emax, 64'd0, dbl) : enc(r.sig, emax - 1, fmask, dbl);
      fl  = 5'b00101;
    end else begin
      res = enc(r.sig, e, m & fmask, dbl);
      fl  = {3'b000, tiny, nx};
    end
    return {fl, res};
  endfunction

  function automatic fp_rnd_in_type rand_rec();
    fp_rnd_in_type r;
    bit dbl;
    int p, emax, ex;
    longint unsigned frac;
    r    = '0;
    dbl  = ($urandom_range(0, 1) == 1);
    p    = dbl ? 53 : 24;
    emax = dbl ? 2047 : 255;
    case ($urandom_range(0, 5))
      0:       ex = 0;
      1:       ex = emax - 1;
      2:       ex = emax;
      3:       ex = 1;
      default: ex = $urandom_range(0, emax - 1);
    endcase
    frac = {$urandom(), $urandom()};
    if ($urandom_range(0, 3) == 0) frac = '1;
    frac = frac & ((64'd1 << (p - 1)) - 1);
    if (ex != 0) frac = frac | (64'd1 << (p - 1));
    r.fmt  = dbl ? 2'd1 : 2'd0;
    r.expo = 14'(ex);
    r.mant = 54'(frac);
    r.sig  = 1'($urandom_range(0, 1));
    r.grs  = 3'($urandom_range(0, 7));
    r.rm   = 3'($urandom_range(0, 7));
    r.rema = 2'($urandom_range(0, 3));
    r.diff = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 5) == 0) {r.snan, r.qnan, r.dbz, r.infs, r.zero} = 5'($urandom_range(1, 31));
    return r;
  endfunction

  // Scoreboard / compare process, sampling on the falling edge.
  logic [68:0] m_e1, m_e0;
  int          m_a;
  logic [63:0] prev_res;
  logic [4:0]  prev_fl;
  bit          prev_stall = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (prev_stall) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", out_result, prev_res);
      chk("hold_flags", 64'(out_flags), 64'(prev_fl));
    end
    if (out_valid && out_ready) begin
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL spurious_output: got result %h, expected no output", out_result);
      end else begin
        m_e1 = q1.pop_front();
        m_e0 = q0.pop_front();
        m_a  = qc.pop_front();
        chk("result", out_result, m_e1[63:0]);
        chk("flags", 64'(out_flags), 64'(m_e1[68:64]));
        chk("valid_riscv0", 64'(out_valid0), 64'd1);
        chk("result_riscv0", out_result0, m_e0[63:0]);
        chk("flags_riscv0", 64'(out_flags0), 64'(m_e0[68:64]));
        n_checks++;
        if (cyc - m_a < 2) begin
          n_fail++;
          $display("FAIL latency: got %0d cycles, expected at least 2", cyc - m_a);
        end
        n_xfer++;
      end
    end
    if (!reset || flush) begin
      q1.delete(); q0.delete(); qc.delete();
    end else if (in_valid && in_ready) begin
      q1.push_back(model(in_rnd, 1'b1));
      q0.push_back(model(in_rnd, 1'b0));
      qc.push_back(cyc);
    end
    prev_stall = out_valid && !out_ready && reset && !flush;
    prev_res   = out_result;
    prev_fl    = out_flags;
  end

  task automatic send(input fp_rnd_in_type r);
    bit ok;
    ok       = 1'b0;
    in_rnd   = r;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got in_ready 0, expected 1 within 100 cycles");
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok        = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (q1.size() == 0 && !out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", q1.size());
    end
    @(posedge clock); #1;
  endtask

  fp_rnd_in_type r1, r2, r3, r4, r5, r6, ra, rb, rc;
  logic [68:0]   exp_a;
  int            x0, sent;
  bit            acc;

  initial begin
    r1 = '0; r1.expo = 14'd127; r1.mant = 54'h80_0000; r1.grs = 3'b100; r1.rm = 3'd0;
    r2 = '0; r2.expo = 14'd254; r2.mant = 54'hFF_FFFF; r2.grs = 3'b100; r2.rm = 3'd0;
    r3 = r2; r3.rm = 3'd1;
    r4 = '0; r4.fmt = 2'd1; r4.mant = 54'd1; r4.grs = 3'b010; r4.rm = 3'd0;
    r5 = '0; r5.fmt = 2'd1; r5.mant = 54'h0_000F_FFFF_FFFF_FFFF; r5.grs = 3'b111; r5.rm = 3'd3;
    r6 = '0; r6.fmt = 2'd1; r6.snan = 1'b1; r6.sig = 1'b1;

    // Hand-computed values pinning the reference model.
    chk("model_tie_even", model(r1, 1'b1)[63:0], 64'hFFFF_FFFF_3F80_0000);
    chk("model_tie_even_flags", 64'(model(r1, 1'b1)[68:64]), 64'(5'b00001));
    chk("model_ovf_rne", model(r2, 1'b1)[63:0], 64'hFFFF_FFFF_7F80_0000);
    chk("model_ovf_rne_flags", 64'(model(r2, 1'b1)[68:64]), 64'(5'b00101));
    chk("model_rtz_max", model(r3, 1'b1)[63:0], 64'hFFFF_FFFF_7F7F_FFFF);
    chk("model_rtz_max_flags", 64'(model(r3, 1'b1)[68:64]), 64'(5'b00001));
    chk("model_dsub", model(r4, 1'b1)[63:0], 64'h0000_0000_0000_0001);
    chk("model_dsub_flags", 64'(model(r4, 1'b1)[68:64]), 64'(5'b00011));
    chk("model_promote", model(r5, 1'b1)[63:0], 64'h0010_0000_0000_0000);
    chk("model_promote_flags", 64'(model(r5, 1'b1)[68:64]), 64'(5'b00011));
    chk("model_snan_riscv", model(r6, 1'b1)[63:0], 64'h7FF8_0000_0000_0000);
    chk("model_snan_flags", 64'(model(r6, 1'b1)[68:64]), 64'(5'b10000));
    chk("model_snan_sign", model(r6, 1'b0)[63:0], 64'hFFF8_0000_0000_0000);

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    out_ready = 1'b1;

    // Accept-to-output latency with literal expectations.
    in_rnd = r1; in_valid = 1'b1;
    @(negedge clock);
    chk("lat_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clock);
    chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
    chk("lat_result", out_result, 64'hFFFF_FFFF_3F80_0000);
    chk("lat_flags", 64'(out_flags), 64'(5'b00001));
    @(posedge clock); #1;

    // Remaining directed vectors, back to back.
    send(r2); send(r3); send(r4); send(r5); send(r6);
    drain();

    // Stall: two entries held, third blocked; release delivers all in order.
    out_ready = 1'b0;
    x0 = n_xfer;
    ra = rand_rec(); rb = rand_rec(); rc = rand_rec();
    exp_a = model(ra, 1'b1);
    send(ra); send(rb);
    in_rnd = rc; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_hold_a", out_result, exp_a[63:0]);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(negedge clock);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_valid_a", 64'(out_valid), 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("release_valid_b", 64'(out_valid), 64'd1);
    @(negedge clock);
    chk("release_valid_c", 64'(out_valid), 64'd1);
    @(posedge clock); #1;
    drain();
    chk("stall_delivered", 64'(n_xfer - x0), 64'd3);

    // Flush (mode 0) and reset (mode 1) with two entries in flight.
    for (int mode = 0; mode < 2; mode++) begin
      out_ready = 1'b0;
      send(rand_rec()); send(rand_rec());
      if (mode == 0) flush = 1'b1; else reset = 1'b0;
      @(posedge clock); #1;
      flush = 1'b0; reset = 1'b1;
      @(negedge clock);
      chk("drop_out_valid", 64'(out_valid), 64'd0);
      chk("drop_in_ready", 64'(in_ready), 64'd1);
      chk("drop_out_result", out_result, 64'd0);
      chk("drop_out_flags", 64'(out_flags), 64'd0);
      @(posedge clock); #1;
      out_ready = 1'b1;
      x0 = n_xfer;
      send(r1);
      drain();
      chk("drop_next_completes", 64'(n_xfer - x0), 64'd1);
    end

    // Random traffic with random backpressure.
    x0 = n_xfer;
    sent = 0;
    for (int t = 0; t < 3000 && sent < 400; t++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_rnd = rand_rec(); in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      acc = in_valid && in_ready;
      @(posedge clock); #1;
      if (acc) begin in_valid = 1'b0; sent++; end
    end
    in_valid = 1'b0;
    drain();
    chk("random_delivered", 64'(n_xfer - x0), 64'(sent));
    chk("final_queue_empty", 64'(q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
